tile_fetch_scheduler: RTL and testbench

Per-scanline sequencer that prefetches the next line's tile pixels into a ping-pong line buffer for the tile renderer. It walks the tilemap RAM, then the pattern RAM, then writes the line buffer, timed from the vga_counters hcount/vcount. It also arbitrates both single-port RAMs between its own fetches and CPU writes, with the scheduler having priority.

---
 rtl/tile_pkg.sv | 25 ++
 rtl/tile_ram_arbiter.sv | 72 +++++++
 rtl/tile_fetch_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tile_fetch_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared constants, fetch FSM state type and tilemap row addressing helper
// for the scanline tile fetch scheduler.
package tile_pkg;

  localparam int H_ACTIVE      = 640;
  localparam int V_ACTIVE      = 480;
  localparam int V_LAST        = 524;
  localparam int TILES_PER_ROW = 80;
  localparam int TILE_ROWS     = 60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAP_RD = 2'd1,
    PAT_RD = 2'd2,
    LB_WR  = 2'd3
  } fetch_state_t;

  // First tilemap entry of a tile row: row*80 as (row<<6)+(row<<4).
  function automatic logic [12:0] map_row_base(input logic [5:0] row);
    logic [12:0] r;
    r = {7'd0, row};
    return (r << 6) + (r << 4);
  endfunction

endpackage

// File: rtl/tile_ram_arbiter.sv
// Shares the single-port tilemap and pattern RAMs between the fetch FSM
// (always wins) and CPU writes (granted only when the port is free).
module tile_ram_arbiter #(
  parameter int MAP_AW = 13,
  parameter int PAT_AW = 11,
  parameter int PIX_W  = 32
) (
  input  logic              map_rd_req,
  input  logic [MAP_AW-1:0] map_rd_addr,
  input  logic              pat_rd_req,
  input  logic [PAT_AW-1:0] pat_rd_addr,
  input  logic              cpu_wr,
  input  logic              cpu_sel,
  input  logic [MAP_AW-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_wdata,
  output logic              map_en,
  output logic              map_we,
  output logic [MAP_AW-1:0] map_addr,
  output logic [7:0]        map_wdata,
  output logic              pat_en,
  output logic              pat_we,
  output logic [PAT_AW-1:0] pat_addr,
  output logic [PIX_W-1:0]  pat_wdata,
  output logic              cpu_ready
);

  logic map_grant;
  logic pat_grant;

  assign map_grant = cpu_wr & ~cpu_sel & ~map_rd_req;
  assign pat_grant = cpu_wr &  cpu_sel & ~pat_rd_req;
  assign cpu_ready = map_grant | pat_grant;

  // Tilemap port: scheduler read first, then a granted CPU write, else idle.
  always_comb begin
    map_en    = 1'b0;
    map_we    = 1'b0;
    map_addr  = {MAP_AW{1'b0}};
    map_wdata = 8'd0;
    if (map_rd_req) begin
      map_en   = 1'b1;
      map_addr = map_rd_addr;
    end else if (map_grant) begin
      map_en    = 1'b1;
      map_we    = 1'b1;
      map_addr  = cpu_addr;
      map_wdata = cpu_wdata[7:0];
    end else begin
      map_en = 1'b0;
    end
  end

  // Pattern port: scheduler read first, then a granted CPU write, else idle.
  always_comb begin
    pat_en    = 1'b0;
    pat_we    = 1'b0;
    pat_addr  = {PAT_AW{1'b0}};
    pat_wdata = {PIX_W{1'b0}};
    if (pat_rd_req) begin
      pat_en   = 1'b1;
      pat_addr = pat_rd_addr;
    end else if (pat_grant) begin
      pat_en    = 1'b1;
      pat_we    = 1'b1;
      pat_addr  = cpu_addr[PAT_AW-1:0];
      pat_wdata = cpu_wdata;
    end else begin
      pat_en = 1'b0;
    end
  end

endmodule

// File: rtl/tile_fetch_scheduler.sv
// Per-scanline prefetch of the next line's tile pixel rows into a ping-pong
// line buffer: tilemap read, pattern read, line-buffer write, 3 cycles/tile.
module tile_fetch_scheduler #(
  parameter int TILES_PER_ROW = 80,
  parameter int MAP_AW        = 13,
  parameter int PAT_AW        = 11,
  parameter int PIX_W         = 32
) (
  input  logic              VGA_CLK,
  input  logic              VGA_RESET_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic              map_en,
  output logic              map_we,
  output logic [MAP_AW-1:0] map_addr,
  output logic [7:0]        map_wdata,
  input  logic [7:0]        map_rdata,
  output logic              pat_en,
  output logic              pat_we,
  output logic [PAT_AW-1:0] pat_addr,
  output logic [PIX_W-1:0]  pat_wdata,
  input  logic [PIX_W-1:0]  pat_rdata,
  output logic              lb_we,
  output logic [7:0]        lb_addr,
  output logic [PIX_W-1:0]  lb_wdata,
  input  logic              cpu_wr,
  input  logic              cpu_sel,
  input  logic [MAP_AW-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_wdata,
  output logic              cpu_ready,
  output logic              busy,
  output logic              overrun
);
  import tile_pkg::*;

  fetch_state_t state_r, state_n;
  logic [6:0]   tile_r, tile_n;
  logic [2:0]   pix_row_r, pix_row_n;
  logic         bank_r, bank_n;
  logic [12:0]  row_base_r, row_base_n;
  logic         overrun_r, overrun_n;

  logic         trigger;
  logic [8:0]   nl;
  logic         last_tile;
  logic         sch_map_rd;
  logic         sch_pat_rd;
  logic [MAP_AW-1:0] sch_map_addr;
  logic [PAT_AW-1:0] sch_pat_addr;
  logic         cpu_req;

  // Line 524 prefetches line 0; lines 0..478 prefetch the following line.
  assign trigger   = (hcount == 10'd0) && ((vcount <= 10'd478) || (vcount == 10'd524));
  assign nl        = (vcount == 10'd524) ? 9'd0 : (vcount[8:0] + 9'd1);
  assign last_tile = (tile_r == 7'(TILES_PER_ROW - 1));

  // Next-state logic; a trigger always restarts at tile 0 and flags overrun if busy.
  always_comb begin
    state_n    = state_r;
    tile_n     = tile_r;
    pix_row_n  = pix_row_r;
    bank_n     = bank_r;
    row_base_n = row_base_r;
    overrun_n  = overrun_r;
    if (trigger) begin
      state_n    = MAP_RD;
      tile_n     = 7'd0;
      pix_row_n  = nl[2:0];
      bank_n     = nl[0];
      row_base_n = map_row_base(nl[8:3]);
      if (state_r != IDLE) begin
        overrun_n = 1'b1;
      end else begin
        overrun_n = overrun_r;
      end
    end else begin
      case (state_r)
        IDLE:    state_n = IDLE;
        MAP_RD:  state_n = PAT_RD;
        PAT_RD:  state_n = LB_WR;
        LB_WR: begin
          if (last_tile) begin
            state_n = IDLE;
            tile_n  = 7'd0;
          end else begin
            state_n = MAP_RD;
            tile_n  = tile_r + 7'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Fetch state and per-line context registers.
  always_ff @(posedge VGA_CLK or negedge VGA_RESET_n) begin
    if (!VGA_RESET_n) begin
      state_r    <= IDLE;
      tile_r     <= 7'd0;
      pix_row_r  <= 3'd0;
      bank_r     <= 1'b0;
      row_base_r <= 13'd0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      tile_r     <= tile_n;
      pix_row_r  <= pix_row_n;
      bank_r     <= bank_n;
      row_base_r <= row_base_n;
      overrun_r  <= overrun_n;
    end
  end

  assign sch_map_rd   = (state_r == MAP_RD);
  assign sch_pat_rd   = (state_r == PAT_RD);
  assign sch_map_addr = MAP_AW'(row_base_r + {6'd0, tile_r});
  assign sch_pat_addr = PAT_AW'({map_rdata, pix_row_r});
  assign busy         = (state_r != IDLE);
  assign overrun      = overrun_r;
  // CPU requests are ignored while reset is held so every RAM enable stays low.
  assign cpu_req      = cpu_wr & VGA_RESET_n;

  // Line-buffer write; an abandoned tile (trigger in its write cycle) is dropped.
  always_comb begin
    lb_we    = 1'b0;
    lb_addr  = 8'd0;
    lb_wdata = {PIX_W{1'b0}};
    if ((state_r == LB_WR) && !trigger) begin
      lb_we    = 1'b1;
      lb_addr  = {bank_r, tile_r};
      lb_wdata = pat_rdata;
    end else begin
      lb_we = 1'b0;
    end
  end

  tile_ram_arbiter #(
    .MAP_AW (MAP_AW),
    .PAT_AW (PAT_AW),
    .PIX_W  (PIX_W)
  ) u_arb (
    .map_rd_req  (sch_map_rd),
    .map_rd_addr (sch_map_addr),
    .pat_rd_req  (sch_pat_rd),
    .pat_rd_addr (sch_pat_addr),
    .cpu_wr      (cpu_req),
    .cpu_sel     (cpu_sel),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .map_en      (map_en),
    .map_we      (map_we),
    .map_addr    (map_addr),
    .map_wdata   (map_wdata),
    .pat_en      (pat_en),
    .pat_we      (pat_we),
    .pat_addr    (pat_addr),
    .pat_wdata   (pat_wdata),
    .cpu_ready   (cpu_ready)
  );

endmodule

// File: tb/tb_tile_fetch_scheduler.sv
// Directed bench for tile_fetch_scheduler with behavioural tilemap/pattern RAMs.
module tb_tile_fetch_scheduler;

  logic        VGA_CLK = 1'b0;
  logic        VGA_RESET_n;
  logic [9:0]  hcount, vcount;
  logic        map_en, map_we, pat_en, pat_we, lb_we;
  logic [12:0] map_addr;
  logic [7:0]  map_wdata;
  logic [7:0]  map_rdata = 8'd0;
  logic [10:0] pat_addr;
  logic [31:0] pat_wdata;
  logic [31:0] pat_rdata = 32'd0;
  logic [7:0]  lb_addr;
  logic [31:0] lb_wdata;
  logic        cpu_wr, cpu_sel, cpu_ready, busy, overrun;
  logic [12:0] cpu_addr;
  logic [31:0] cpu_wdata;

  int n_cmp = 0;
  int n_err = 0;
  int t, ph;

  // Memories: unwritten words read back a fixed pattern of their address.
  logic [7:0]  map_mem [0:8191];
  logic        map_wr  [0:8191];
  logic [31:0] pat_mem [0:2047];
  logic        pat_wr  [0:2047];

  tile_fetch_scheduler dut (
    .VGA_CLK(VGA_CLK), .VGA_RESET_n(VGA_RESET_n), .hcount(hcount), .vcount(vcount),
    .map_en(map_en), .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
    .map_rdata(map_rdata), .pat_en(pat_en), .pat_we(pat_we), .pat_addr(pat_addr),
    .pat_wdata(pat_wdata), .pat_rdata(pat_rdata), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_wdata(lb_wdata), .cpu_wr(cpu_wr), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .busy(busy), .overrun(overrun)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  function automatic logic [7:0] map_rd(input logic [12:0] a);
    return (map_wr[a] === 1'b1) ? map_mem[a] : a[7:0];
  endfunction

  function automatic logic [31:0] pat_init(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  function automatic logic [31:0] pat_rd(input logic [10:0] a);
    return (pat_wr[a] === 1'b1) ? pat_mem[a] : pat_init(int'(a));
  endfunction

  // Single-port synchronous RAM models with 1-cycle read latency.
  always @(posedge VGA_CLK) begin
    if (map_en) begin
      if (map_we) begin
        map_mem[map_addr] <= map_wdata;
        map_wr[map_addr]  <= 1'b1;
      end else begin
        map_rdata <= map_rd(map_addr);
      end
    end
    if (pat_en) begin
      if (pat_we) begin
        pat_mem[pat_addr] <= pat_wdata;
        pat_wr[pat_addr]  <= 1'b1;
      end else begin
        pat_rdata <= pat_rd(pat_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one pixel clock, drive the counters, let combinational outputs settle.
  task automatic tick(input int v, input int h);
    @(posedge VGA_CLK);
    #1;
    vcount = v[9:0];
    hcount = h[9:0];
    #3;
  endtask

  task automatic run_line(input int v, input int h0);
    for (int h = h0; h <= 241; h++) tick(v, h);
  endtask

  initial begin
    VGA_RESET_n = 1'b0;
    hcount = 10'd0; vcount = 10'd0;
    cpu_wr = 1'b0; cpu_sel = 1'b0; cpu_addr = 13'd0; cpu_wdata = 32'd0;

    // Reset state (trigger condition present but held off by reset)
    #2;
    chk("rst_map_en", map_en, 32'd0);
    chk("rst_pat_en", pat_en, 32'd0);
    chk("rst_lb_we", lb_we, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_overrun", overrun, 32'd0);
    tick(523, 700);
    chk("rst_map_addr", map_addr, 32'd0);
    chk("rst_lb_addr", lb_addr, 32'd0);
    chk("rst_busy2", busy, 32'd0);
    VGA_RESET_n = 1'b1;
    tick(523, 701);

    // Line 524 prefetches line 0, bank 0, map addresses 0..79
    tick(524, 0);
    chk("t1_busy_trigger", busy, 32'd0);
    for (int h = 1; h <= 240; h++) begin
      tick(524, h);
      t  = (h - 1) / 3;
      ph = (h - 1) % 3;
      chk($sformatf("t1_busy_h%0d", h), busy, 32'd1);
      case (ph)
        0: begin
          chk($sformatf("t1_map_en_h%0d", h), map_en, 32'd1);
          chk($sformatf("t1_map_addr_h%0d", h), map_addr, 32'(t));
        end
        1: chk($sformatf("t1_pat_addr_h%0d", h), pat_addr, 32'(t * 8));
        default: begin
          chk($sformatf("t1_lb_we_h%0d", h), lb_we, 32'd1);
          chk($sformatf("t1_lb_addr_h%0d", h), lb_addr, 32'(t));
          chk($sformatf("t1_lb_wdata_h%0d", h), lb_wdata, pat_init(t * 8));
        end
      endcase
    end
    tick(524, 241);
    chk("t1_busy_end", busy, 32'd0);
    chk("t1_lb_we_end", lb_we, 32'd0);

    // CPU preloads on an idle line
    cpu_wr = 1'b1; cpu_sel = 1'b0; cpu_addr = 13'd165; cpu_wdata = 32'h0000_002A;
    tick(500, 10);
    chk("pre_map_ready", cpu_ready, 32'd1);
    chk("pre_map_we", map_we, 32'd1);
    cpu_sel = 1'b1; cpu_addr = 13'h0152; cpu_wdata = 32'hDEAD_BEEF;
    tick(500, 11);
    chk("pre_pat_ready", cpu_ready, 32'd1);
    chk("pre_pat_we", pat_we, 32'd1);
    cpu_wr = 1'b0;
    tick(500, 12);

    // vcount 17 -> nl 18: row_base 160, pixel row 2, bank 0; tile 5 uses preloads
    for (int h = 0; h <= 15; h++) tick(17, h);
    tick(17, 16);
    chk("t2_map_addr", map_addr, 32'd165);
    tick(17, 17);
    chk("t2_pat_addr", pat_addr, 32'h152);
    tick(17, 18);
    chk("t2_lb_we", lb_we, 32'd1);
    chk("t2_lb_addr", lb_addr, 32'h05);
    chk("t2_lb_wdata", lb_wdata, 32'hDEAD_BEEF);
    run_line(17, 19);

    // vcount 18 -> nl 19: bank 1, pixel row 3
    tick(18, 0);
    tick(18, 1);
    chk("t3_map_addr", map_addr, 32'd160);
    tick(18, 2);
    tick(18, 3);
    chk("t3_lb_addr", lb_addr, 32'h80);
    chk("t3_lb_wdata", lb_wdata, 32'hA500_0503);
    run_line(18, 4);

    // CPU tilemap write held across a fetch (vcount 19 -> nl 20, row 4)
    cpu_wr = 1'b1; cpu_sel = 1'b0; cpu_addr = 13'd1000; cpu_wdata = 32'h0000_0077;
    for (int h = 0; h <= 8; h++) begin
      tick(19, h);
      if (h >= 1 && ((h - 1) % 3) == 0) begin
        chk($sformatf("t4_ready_h%0d", h), cpu_ready, 32'd0);
        chk($sformatf("t4_map_we_h%0d", h), map_we, 32'd0);
        chk($sformatf("t4_map_addr_h%0d", h), map_addr, 32'(160 + (h - 1) / 3));
      end else begin
        chk($sformatf("t4_ready_h%0d", h), cpu_ready, 32'd1);
      end
      if (h == 2) chk("t4_cpu_addr", map_addr, 32'd1000);
      if (h == 3) chk("t4_lb_wdata0", lb_wdata, pat_init((8'hA0 << 3) | 4));
      if (h == 6) chk("t4_lb_wdata1", lb_wdata, pat_init((8'hA1 << 3) | 4));
    end
    cpu_wr = 1'b0;
    run_line(19, 9);
    chk("t4_map_content", 32'(map_rd(13'd1000)), 32'h77);

    // Blanking lines: no fetch, CPU always ready
    cpu_wr = 1'b1; cpu_sel = 1'b1; cpu_addr = 13'h07FF;
    for (int v = 479; v <= 523; v++) begin
      cpu_wdata = 32'hC0DE_0000 | 32'(v);
      tick(v, 0);
      chk($sformatf("t5_ready_v%0d", v), cpu_ready, 32'd1);
      tick(v, 1);
      chk($sformatf("t5_busy_v%0d", v), busy, 32'd0);
      chk($sformatf("t5_ready1_v%0d", v), cpu_ready, 32'd1);
    end
    cpu_wr = 1'b0;
    tick(523, 2);
    chk("t5_pat_content", pat_rd(11'h7FF), 32'hC0DE_020B);

    // Overrun: retrigger during tile 40's write (vcount 100 -> jump to 107)
    for (int h = 0; h <= 122; h++) tick(100, h);
    chk("t6_overrun_before", overrun, 32'd0);
    tick(107, 0);
    chk("t6_no_lb_we", lb_we, 32'd0);
    tick(107, 1);
    chk("t6_overrun_set", overrun, 32'd1);
    chk("t6_map_addr", map_addr, 32'd1040);
    tick(107, 2);
    chk("t6_pat_addr", pat_addr, 32'h84);
    tick(107, 3);
    chk("t6_lb_addr", lb_addr, 32'h00);
    chk("t6_lb_wdata", lb_wdata, 32'hA500_0084);
    run_line(107, 4);
    chk("t6_overrun_sticky", overrun, 32'd1);
    chk("t6_busy_end", busy, 32'd0);

    // Reset during LB_WR (vcount 200 -> nl 201, bank 1)
    for (int h = 0; h <= 2; h++) tick(200, h);
    tick(200, 3);
    chk("t7_lb_addr", lb_addr, 32'h80);
    chk("t7_lb_wdata", lb_wdata, 32'hA500_0681);
    tick(200, 4); tick(200, 5); tick(200, 6);
    chk("t7_lb_we_pre", lb_we, 32'd1);
    VGA_RESET_n = 1'b0;
    #1;
    chk("t7_rst_lb_we", lb_we, 32'd0);
    chk("t7_rst_lb_addr", lb_addr, 32'd0);
    chk("t7_rst_busy", busy, 32'd0);
    chk("t7_rst_overrun", overrun, 32'd0);
    chk("t7_rst_map_en", map_en, 32'd0);
    tick(200, 7);
    chk("t7_rst_hold_busy", busy, 32'd0);
    VGA_RESET_n = 1'b1;
    tick(200, 8);
    chk("t7_idle_after", busy, 32'd0);
    tick(201, 0);
    tick(201, 1);
    chk("t7_resume_busy", busy, 32'd1);
    chk("t7_resume_map_addr", map_addr, 32'd2000);
    tick(201, 2);
    tick(201, 3);
    chk("t7_resume_lb_addr", lb_addr, 32'h00);
    chk("t7_resume_lb_wdata", lb_wdata, 32'hA500_0682);
    chk("t7_overrun_clear", overrun, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
